// File: rtl/vote_tally_fsm.sv
// One-vote-per-session tally: accepts a single one-hot vote after an officer arms
// the booth, rejects multi-hot input, and keeps saturating per-candidate and total counts.
module vote_tally_fsm #(
  parameter int NUM_CAND       = 4,
  parameter int COUNT_W        = 8,
  parameter int CONFIRM_CYCLES = 100,
  localparam int SW = ($clog2(NUM_CAND) < 1) ? 1 : $clog2(NUM_CAND)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CAND-1:0]   vote_valid,
  input  logic                  officer_arm,
  input  logic                  clear_counts,
  input  logic [SW-1:0]         sel,
  output logic                  armed,
  output logic                  confirm_led,
  output logic                  vote_accepted,
  output logic [SW-1:0]         accepted_id,
  output logic                  error_multi,
  output logic                  overflow,
  output logic [COUNT_W-1:0]    tally_out,
  output logic [COUNT_W+SW-1:0] total_votes,
  output logic [1:0]            dbg_state
);

  localparam int TW    = COUNT_W + SW;
  localparam int CNT_W = ($clog2(CONFIRM_CYCLES + 1) < 1) ? 1 : $clog2(CONFIRM_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CONFIRM = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COUNT_W-1:0] tally_q [NUM_CAND];
  logic [COUNT_W-1:0] tally_d [NUM_CAND];
  logic [TW-1:0]      total_q, total_d;
  logic               ovf_q, ovf_d;
  logic               acc_q, acc_d;
  logic               err_q, err_d;
  logic [SW-1:0]      id_q, id_d;
  logic [COUNT_W-1:0] tout_q, tout_d;

  logic               multi_hot;
  logic               single_hot;
  logic [SW-1:0]      vote_idx;

  // x & (x-1) is nonzero exactly when two or more bits are set.
  assign multi_hot  = |(vote_valid & (vote_valid - NUM_CAND'(1)));
  assign single_hot = (|vote_valid) & ~multi_hot;

  always_comb begin
    vote_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_valid[i]) vote_idx = vote_idx | SW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tally_d = tally_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    acc_d   = 1'b0;
    err_d   = 1'b0;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (officer_arm) state_d = S_ARMED;
        if (clear_counts) begin
          for (int i = 0; i < NUM_CAND; i++) tally_d[i] = '0;
          total_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (single_hot) begin
          acc_d   = 1'b1;
          id_d    = vote_idx;
          state_d = S_CONFIRM;
          cnt_d   = CNT_W'(CONFIRM_CYCLES - 1);
          // A saturated counter still lets the vote through; only overflow records it.
          for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_valid[i]) begin
              if (tally_q[i] == '1) ovf_d = 1'b1;
              else                  tally_d[i] = tally_q[i] + COUNT_W'(1);
            end
          end
          if (total_q == '1) ovf_d = 1'b1;
          else               total_d = total_q + TW'(1);
        end else if (multi_hot) begin
          err_d = 1'b1;
        end
      end
      S_CONFIRM: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Out-of-range sel matches no entry and reads back zero.
  always_comb begin
    tout_d = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (sel == SW'(i)) tout_d = tally_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      acc_q   <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tally_q <= tally_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      id_q    <= id_d;
      tout_q  <= tout_d;
    end
  end

  assign armed         = (state_q == S_ARMED);
  assign confirm_led   = (state_q == S_CONFIRM);
  assign vote_accepted = acc_q;
  assign accepted_id   = id_q;
  assign error_multi   = err_q;
  assign overflow      = ovf_q;
  assign tally_out     = tout_q;
  assign total_votes   = total_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_vote_tally_fsm.sv
// Bench for vote_tally_fsm with 4 candidates and 2-bit tallies so saturation is reachable.
module tb_vote_tally_fsm;

  localparam int NC    = 4;
  localparam int CW    = 2;
  localparam int SW    = 2;
  localparam int TW    = CW + SW;
  localparam int CONF  = 100;
  localparam int TMAX  = (1 << CW) - 1;
  localparam int TOTMX = (1 << TW) - 1;

  logic          clock;
  logic          reset;
  logic [NC-1:0] vote_valid;
  logic          officer_arm;
  logic          clear_counts;
  logic [SW-1:0] sel;
  logic          armed;
  logic          confirm_led;
  logic          vote_accepted;
  logic [SW-1:0] accepted_id;
  logic          error_multi;
  logic          overflow;
  logic [CW-1:0] tally_out;
  logic [TW-1:0] total_votes;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  logic [SW-1:0] exp_q[$];
  int m_tally [NC];
  int m_total;
  logic m_ovf;

  vote_tally_fsm #(
    .NUM_CAND(NC), .COUNT_W(CW), .CONFIRM_CYCLES(CONF)
  ) dut (
    .clock(clock), .reset(reset), .vote_valid(vote_valid),
    .officer_arm(officer_arm), .clear_counts(clear_counts), .sel(sel),
    .armed(armed), .confirm_led(confirm_led), .vote_accepted(vote_accepted),
    .accepted_id(accepted_id), .error_multi(error_multi), .overflow(overflow),
    .tally_out(tally_out), .total_votes(total_votes), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard monitor: every accept pulse must match the oldest expected id
  always begin
    @(posedge clock);
    #1;
    if (vote_accepted === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_accept: id=%0d, no accept expected", accepted_id);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        if (accepted_id !== e) begin
          errors++;
          $display("FAIL sb_accepted_id: got %0d expected %0d", accepted_id, e);
        end
      end
    end
    if (error_multi === 1'b1) err_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_arm();
    officer_arm = 1'b1;
    tick();
    officer_arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
  endtask

  task automatic cast_vote(input logic [NC-1:0] v);
    vote_valid = v;
    tick();
    vote_valid = '0;
  endtask

  task automatic model_accept(input int id);
    if (m_tally[id] == TMAX) m_ovf = 1'b1;
    else                     m_tally[id]++;
    if (m_total == TOTMX)    m_ovf = 1'b1;
    else                     m_total++;
    exp_q.push_back(SW'(id));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) m_tally[i] = 0;
    m_total = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic count_confirm(output int n);
    n = 0;
    while (confirm_led === 1'b1 && n < 3 * CONF) begin
      n++;
      tick();
    end
  endtask

  task automatic vote_session(input int id);
    int n;
    pulse_arm();
    model_accept(id);
    cast_vote(NC'(1) << id);
    count_confirm(n);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    vote_valid = '0; officer_arm = 1'b0; clear_counts = 1'b0; sel = '0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({armed, confirm_led, vote_accepted, error_multi, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {armed, confirm_led, vote_accepted, error_multi, overflow});
    end
    checks++;
    if ({accepted_id, tally_out, total_votes, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_values: id=%0d tally=%0d total=%0d state=%0d expected all 0",
               accepted_id, tally_out, total_votes, dbg_state);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_vote();
    int n;
    pulse_arm();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL single_armed: got %b expected 1", armed); end
    model_accept(2);
    cast_vote(4'b0100);
    checks++;
    if ({vote_accepted, armed, confirm_led} !== 3'b101) begin
      errors++;
      $display("FAIL single_accept_edge: acc/armed/led got %b expected 101",
               {vote_accepted, armed, confirm_led});
    end
    checks++;
    if (total_votes !== TW'(m_total)) begin
      errors++; $display("FAIL single_total: got %0d expected %0d", total_votes, m_total);
    end
    tick();
    checks++;
    if (vote_accepted !== 1'b0) begin
      errors++; $display("FAIL single_accept_pulse_width: got %b expected 0", vote_accepted);
    end
    count_confirm(n);
    checks++;
    if (n + 1 != CONF) begin
      errors++; $display("FAIL single_confirm_len: got %0d expected %0d", n + 1, CONF);
    end
    checks++;
    if ({armed, confirm_led, dbg_state} !== 4'b0) begin
      errors++; $display("FAIL single_back_idle: armed=%b led=%b state=%0d expected 0",
                         armed, confirm_led, dbg_state);
    end
    sel = 2'd2;
    tick();
    checks++;
    if (tally_out !== CW'(1)) begin
      errors++; $display("FAIL single_readout: got %0d expected 1", tally_out);
    end
  endtask

  task automatic test_lockout();
    int n;
    int e0;
    e0 = err_cnt;
    pulse_arm();
    model_accept(0);
    cast_vote(4'b0001);
    repeat (5) tick();
    cast_vote(4'b0010);
    count_confirm(n);
    cast_vote(4'b1000);
    cast_vote(4'b0110);
    pulse_arm();
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL lockout_rearm: got %b expected 1", armed); end
    cast_vote(4'b0000);
    checks++;
    if (err_cnt != e0) begin
      errors++; $display("FAIL lockout_no_error: got %0d pulses expected 0", err_cnt - e0);
    end
    for (int i = 0; i < NC; i++) begin
      sel = SW'(i);
      tick();
      checks++;
      if (tally_out !== CW'(m_tally[i])) begin
        errors++; $display("FAIL lockout_tally%0d: got %0d expected %0d", i, tally_out, m_tally[i]);
      end
    end
    checks++;
    if (total_votes !== TW'(m_total)) begin
      errors++; $display("FAIL lockout_total: got %0d expected %0d", total_votes, m_total);
    end
  endtask

  task automatic test_multi_hot();
    int n;
    int e0;
    e0 = err_cnt;
    cast_vote(4'b0011);
    checks++;
    if ({error_multi, armed} !== 2'b11) begin
      errors++; $display("FAIL multi_err_edge: err/armed got %b expected 11", {error_multi, armed});
    end
    cast_vote(4'b1111);
    tick();
    checks++;
    if (err_cnt != e0 + 2 || error_multi !== 1'b0) begin
      errors++; $display("FAIL multi_err_pulses: got %0d (now %b) expected 2 (now 0)",
                         err_cnt - e0, error_multi);
    end
    checks++;
    if (total_votes !== TW'(m_total)) begin
      errors++; $display("FAIL multi_total_kept: got %0d expected %0d", total_votes, m_total);
    end
    model_accept(1);
    cast_vote(4'b0010);
    count_confirm(n);
    sel = 2'd1;
    tick();
    checks++;
    if (tally_out !== CW'(m_tally[1])) begin
      errors++; $display("FAIL multi_tally1: got %0d expected %0d", tally_out, m_tally[1]);
    end
  endtask

  task automatic test_clear_gating();
    int n;
    pulse_arm();
    pulse_clear();
    model_accept(0);
    cast_vote(4'b0001);
    repeat (3) tick();
    pulse_clear();
    count_confirm(n);
    checks++;
    if (total_votes !== TW'(m_total)) begin
      errors++; $display("FAIL clear_ignored_busy: total got %0d expected %0d", total_votes, m_total);
    end
    officer_arm = 1'b1;
    vote_valid  = 4'b0001;
    tick();
    officer_arm = 1'b0;
    vote_valid  = '0;
    tick();
    checks++;
    if (armed !== 1'b1 || total_votes !== TW'(m_total)) begin
      errors++; $display("FAIL collision_arm_vote: armed=%b total=%0d expected 1/%0d",
                         armed, total_votes, m_total);
    end
    model_accept(3);
    cast_vote(4'b1000);
    count_confirm(n);
    officer_arm  = 1'b1;
    clear_counts = 1'b1;
    tick();
    officer_arm  = 1'b0;
    clear_counts = 1'b0;
    model_clear();
    checks++;
    if (armed !== 1'b1 || total_votes !== '0) begin
      errors++; $display("FAIL clear_with_arm: armed=%b total=%0d expected 1/0", armed, total_votes);
    end
    model_accept(2);
    cast_vote(4'b0100);
    count_confirm(n);
  endtask

  task automatic test_saturation();
    pulse_clear();
    model_clear();
    for (int k = 1; k <= 5; k++) begin
      vote_session(3);
      checks++;
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL sat_overflow_vote%0d: got %b expected %b", k, overflow, m_ovf);
      end
    end
    sel = 2'd3;
    tick();
    checks++;
    if (tally_out !== CW'(TMAX) || total_votes !== TW'(5)) begin
      errors++; $display("FAIL sat_values: tally3=%0d total=%0d expected %0d/5",
                         tally_out, total_votes, TMAX);
    end
    pulse_clear();
    model_clear();
    tick();
    checks++;
    if (tally_out !== '0 || total_votes !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL sat_clear: tally3=%0d total=%0d ovf=%b expected 0/0/0",
                         tally_out, total_votes, overflow);
    end
  endtask

  task automatic test_total_saturation();
    for (int k = 0; k < TOTMX + 1; k++) vote_session($urandom_range(0, NC - 1));
    checks++;
    if (total_votes !== TW'(TOTMX) || overflow !== 1'b1) begin
      errors++; $display("FAIL total_sat: total=%0d ovf=%b expected %0d/1",
                         total_votes, overflow, TOTMX);
    end
    for (int i = 0; i < NC; i++) begin
      sel = SW'(i);
      tick();
      checks++;
      if (tally_out !== CW'(m_tally[i])) begin
        errors++; $display("FAIL total_sat_tally%0d: got %0d expected %0d", i, tally_out, m_tally[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_arm();
    model_accept(1);
    cast_vote(4'b0010);
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({armed, confirm_led, overflow} !== 3'b0 || total_votes !== '0 || accepted_id !== '0) begin
      errors++; $display("FAIL async_reset_immediate: led=%b ovf=%b total=%0d id=%0d expected 0",
                         confirm_led, overflow, total_votes, accepted_id);
    end
    #3;
    reset = 1'b1;
    model_clear();
    tick();
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++; $display("FAIL async_reset_state: got %0d expected 0", dbg_state);
    end
    for (int i = 0; i < NC; i++) begin
      sel = SW'(i);
      tick();
      checks++;
      if (tally_out !== '0) begin
        errors++; $display("FAIL async_reset_tally%0d: got %0d expected 0", i, tally_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_vote();
    test_lockout();
    test_multi_hot();
    test_clear_gating();
    test_saturation();
    test_total_saturation();
    test_async_reset();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d expected accepts never seen", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vote_tally_fsm.md
Name: vote_tally_fsm

Overview:
- Sits directly downstream of the per-candidate button debounce/long-press stages.
- Consumes their one-cycle valid_vote pulses as a one-hot candidate vector.
- Enforces one vote per officer-armed session, rejects ambiguous (multi-hot) input, and keeps saturating per-candidate and total tallies.
- Provides a registered readout port for the display/results logic.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- COUNT_W, 8, width of each per-candidate tally.
- CONFIRM_CYCLES, 100, number of cycles confirm_led is held after an accepted vote (>=1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- vote_valid  in  NUM_CAND  one-cycle vote pulses from the button stages; bit i = candidate i.
- officer_arm  in  1  single-cycle pulse that opens one voting session.
- clear_counts  in  1  single-cycle pulse that zeroes all tallies.
- sel  in  SW=max(1,$clog2(NUM_CAND))  candidate index for readout.
- armed  out  1  high while a session is open (state ARMED).
- confirm_led  out  1  high during CONFIRM.
- vote_accepted  out  1  one-cycle pulse on each accepted vote.
- accepted_id  out  SW  index of the last accepted candidate; holds its value between votes.
- error_multi  out  1  one-cycle pulse when a multi-hot vote is rejected.
- overflow  out  1  sticky flag, set when any tally or the total saturates.
- tally_out  out  COUNT_W  registered tally of candidate sel.
- total_votes  out  COUNT_W+SW  saturating sum of all accepted votes.

Behaviour:
- Reset: every output and counter is 0 and the state is IDLE. Reset is async assert, sync deassert. Asserting reset mid-session or mid-CONFIRM discards the pending session.
- States and transitions:
  - IDLE --officer_arm--> ARMED.
  - ARMED --exactly one bit of vote_valid set--> CONFIRM.
  - CONFIRM --CONFIRM_CYCLES elapsed--> IDLE.
- ARMED input handling:
  - vote_valid == 0: stay in ARMED.
  - Popcount(vote_valid) >= 2: no tally change, error_multi=1 for one cycle, stay in ARMED.
- Accepting a vote: when a single-hot vote_valid is sampled in ARMED at edge t, the following all hold from edge t:
  - tally[i] and total_votes are incremented.
  - vote_accepted=1 for exactly one cycle.
  - accepted_id=i.
  - state becomes CONFIRM, so armed=0 and confirm_led=1.
- CONFIRM timing: confirm_led stays high for exactly CONFIRM_CYCLES cycles, then the state returns to IDLE.
- vote_valid received in IDLE or CONFIRM is ignored: no tally change and no error pulse.
- officer_arm received in ARMED or CONFIRM is ignored; there is no queuing.
- If officer_arm and vote_valid arrive in the same cycle in IDLE, only the arm is taken. The vote is dropped, because the state is IDLE when it is sampled.
- clear_counts:
  - Honoured only in IDLE. All tallies, total_votes and overflow are 0 after the next edge.
  - Ignored in ARMED and CONFIRM.
  - If it arrives in the same cycle as officer_arm in IDLE, both take effect.
- Saturation:
  - A tally at 2^COUNT_W-1 holds its value. The vote is still accepted (pulse, confirm and id all happen) and overflow is set.
  - total_votes saturates at 2^(COUNT_W+SW)-1 in the same way.
  - overflow clears only on reset or an honoured clear_counts.
- Readout: tally_out = tally[sel] registered, giving 1-cycle latency from a sel change.
  - sel >= NUM_CAND reads 0.
  - On the increment edge, tally_out updates one cycle after the tally.
- Arithmetic: all counters are unsigned, and the CONFIRM counter is wide enough for $clog2(CONFIRM_CYCLES+1) bits.

Test Plan:
- Single vote: reset low then high; officer_arm; vote_valid=4'b0100 one cycle later -> vote_accepted one pulse, accepted_id=2, tally[2]=1, total_votes=1, confirm_led high exactly 100 cycles, then armed=0 in IDLE; sel=2 -> tally_out=1 one cycle later.
- Double-vote lockout: during ARMED, vote 4'b0001; during CONFIRM, vote 4'b0010; after IDLE, vote 4'b1000 with no arm -> only tally[0]=1 and total_votes=1.
- Multi-hot rejection: arm; vote_valid=4'b0011 -> error_multi one pulse, tallies unchanged, armed still 1; then 4'b0010 -> tally[1]=1.
- Saturation: COUNT_W=2; arm and vote candidate 3 five times -> tally[3]=3, total_votes=5, overflow=1 after the 4th vote; clear_counts in IDLE -> all 0 and overflow=0.
- Clear gating and collision:
  - clear_counts during ARMED -> tallies kept.
  - officer_arm and vote_valid=4'b0001 in the same IDLE cycle -> armed=1, no tally change.
- Async reset mid-CONFIRM: reset=0 for half a clock period between edges -> outputs go to 0 immediately, without waiting for a clock edge; after release, state is IDLE and all tallies are 0.
